// File: rtl/vga_pkg.sv
// Shared VGA definitions: display size defaults, RRRGGGBB colour type,
// named colours and the box-update FSM state encoding.
package vga_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    typedef logic [7:0] colour_t;

    localparam colour_t COL_BLACK = 8'h00;
    localparam colour_t COL_WHITE = 8'hFF;
    localparam colour_t COL_RED   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_X = 2'd1,
        STEP_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/bouncing_box_gen_if.sv
// Pixel-source bus between the VGA timing generator (master) and the box generator (slave).
interface bouncing_box_gen_if;
    import vga_pkg::*;

    logic       PIX_EN;
    logic [9:0] ADDRH;
    logic [8:0] ADDRV;
    logic       REFRESH;
    logic       PAUSE;
    logic [2:0] SPEED;
    colour_t    COLOUR;
    logic       HIT;
    logic       CORNER;

    modport master (
        output PIX_EN, ADDRH, ADDRV, REFRESH, PAUSE, SPEED,
        input  COLOUR, HIT, CORNER
    );

    modport slave (
        input  PIX_EN, ADDRH, ADDRV, REFRESH, PAUSE, SPEED,
        output COLOUR, HIT, CORNER
    );

endinterface

// File: rtl/bouncing_box_gen_axis.sv
// Single-axis stepper: moves pos by speed in dir, clamps to [0, LIMIT] and flips dir on contact.
// Purely combinational; the caller registers the result in its STEP state.
module axis_bounce #(
    parameter int W     = 10,
    parameter int LIMIT = 608
) (
    input  logic [W-1:0] pos,
    input  logic         dir,
    input  logic [2:0]   speed,
    output logic [W-1:0] pos_next,
    output logic         dir_next,
    output logic         hit
);

    localparam logic [W-1:0] LIM   = W'(LIMIT);
    localparam logic [10:0]  LIM_W = 11'(LIMIT);

    logic [10:0] pos_w;
    logic [10:0] spd_w;

    assign pos_w = 11'(pos);
    assign spd_w = 11'(speed);

    // Speed 0 is a true hold: a box resting on an edge must not re-trigger a bounce.
    always_comb begin
        pos_next = pos;
        dir_next = dir;
        hit      = 1'b0;
        if (speed != 3'd0) begin
            if (dir) begin
                if (pos_w + spd_w >= LIM_W) begin
                    pos_next = LIM;
                    dir_next = 1'b0;
                    hit      = 1'b1;
                end else begin
                    pos_next = pos + W'(speed);
                end
            end else begin
                if (pos_w <= spd_w) begin
                    pos_next = '0;
                    dir_next = 1'b1;
                    hit      = 1'b1;
                end else begin
                    pos_next = pos - W'(speed);
                end
            end
        end
    end

endmodule

// File: rtl/bouncing_box_gen.sv
// Border + bouncing-box pixel source; the box steps once per REFRESH so frames never tear.
// COLOUR lags ADDRH/ADDRV by one PIX_EN strobe; an update takes 4 cycles with HIT/CORNER in COMMIT.
// No backpressure: REFRESH outside IDLE is dropped.
module bouncing_box_gen
    import vga_pkg::*;
#(
    parameter int      H_RES         = H_RES_DEF,
    parameter int      V_RES         = V_RES_DEF,
    parameter int      BOX_W         = 32,
    parameter int      BOX_H         = 32,
    parameter colour_t BG_COLOUR     = COL_BLACK,
    parameter colour_t BORDER_COLOUR = COL_WHITE,
    parameter colour_t BOX_COLOUR    = COL_RED,
    parameter colour_t COLOUR_STEP   = 8'h25
) (
    input  logic               CLK,
    input  logic               RESETN,
    bouncing_box_gen_if.slave  bus
);

    localparam int          X_MAX   = H_RES - BOX_W;
    localparam int          Y_MAX   = V_RES - BOX_H;
    localparam logic [9:0]  X_RST   = 10'(X_MAX / 2);
    localparam logic [8:0]  Y_RST   = 9'(Y_MAX / 2);
    localparam logic [10:0] BOX_W_W = 11'(BOX_W);
    localparam logic [10:0] BOX_H_W = 11'(BOX_H);
    localparam logic [10:0] H_LAST  = 11'(H_RES - 1);
    localparam logic [10:0] V_LAST  = 11'(V_RES - 1);

    state_t     state;
    logic [9:0] pos_x, shd_x, nx_x;
    logic [8:0] pos_y, shd_y, nx_y;
    logic       dir_x, dir_y, nx_dir_x, nx_dir_y;
    logic       hx, hy, nx_hx, nx_hy;
    colour_t    box_col;

    axis_bounce #(.W(10), .LIMIT(X_MAX)) u_axis_x (
        .pos      (pos_x),
        .dir      (dir_x),
        .speed    (bus.SPEED),
        .pos_next (nx_x),
        .dir_next (nx_dir_x),
        .hit      (nx_hx)
    );

    axis_bounce #(.W(9), .LIMIT(Y_MAX)) u_axis_y (
        .pos      (pos_y),
        .dir      (dir_y),
        .speed    (bus.SPEED),
        .pos_next (nx_y),
        .dir_next (nx_dir_y),
        .hit      (nx_hy)
    );

    // HIT/CORNER are loaded on the STEP_Y edge so they are high exactly while state==COMMIT.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= IDLE;
            pos_x      <= X_RST;
            pos_y      <= Y_RST;
            shd_x      <= X_RST;
            shd_y      <= Y_RST;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            hx         <= 1'b0;
            hy         <= 1'b0;
            box_col    <= BOX_COLOUR;
            bus.HIT    <= 1'b0;
            bus.CORNER <= 1'b0;
        end else begin
            bus.HIT    <= 1'b0;
            bus.CORNER <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.REFRESH && !bus.PAUSE) state <= STEP_X;
                end
                STEP_X: begin
                    shd_x <= nx_x;
                    dir_x <= nx_dir_x;
                    hx    <= nx_hx;
                    state <= STEP_Y;
                end
                STEP_Y: begin
                    shd_y      <= nx_y;
                    dir_y      <= nx_dir_y;
                    hy         <= nx_hy;
                    bus.HIT    <= hx | nx_hy;
                    bus.CORNER <= hx & nx_hy;
                    state      <= COMMIT;
                end
                COMMIT: begin
                    pos_x <= shd_x;
                    pos_y <= shd_y;
                    if (hx | hy) box_col <= box_col + COLOUR_STEP;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [10:0] ah, av, bx0, by0;
    logic        in_box, on_border;

    assign ah  = 11'(bus.ADDRH);
    assign av  = 11'(bus.ADDRV);
    assign bx0 = 11'(pos_x);
    assign by0 = 11'(pos_y);

    assign in_box    = (ah >= bx0) && (ah < bx0 + BOX_W_W) &&
                       (av >= by0) && (av < by0 + BOX_H_W);
    assign on_border = (ah == 11'd0) || (ah == H_LAST) ||
                       (av == 11'd0) || (av == V_LAST);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            bus.COLOUR <= '0;
        end else if (bus.PIX_EN) begin
            bus.COLOUR <= in_box    ? box_col       :
                          on_border ? BORDER_COLOUR : BG_COLOUR;
        end
    end

endmodule

// File: tb/tb_bouncing_box_gen.sv
// Bench for bouncing_box_gen: full-size instance plus a 64x64 instance where both axes bounce together.
module tb_bouncing_box_gen;
    import vga_pkg::*;

    logic CLK = 1'b0;
    logic RESETN;
    always #5 CLK = ~CLK;

    bouncing_box_gen_if bi ();
    bouncing_box_gen_if bs ();

    bouncing_box_gen dut (.CLK(CLK), .RESETN(RESETN), .bus(bi));
    bouncing_box_gen #(.H_RES(64), .V_RES(64)) dsq (.CLK(CLK), .RESETN(RESETN), .bus(bs));

    typedef struct {
        int         h;
        int         v;
        logic [7:0] c;
    } pix_vec_t;

    typedef struct {
        int         px;
        int         py;
        logic       hit;
        logic       corner;
        logic [7:0] col;
    } upd_t;

    int         n_chk  = 0;
    int         n_fail = 0;
    upd_t       upd_q[$];
    logic [7:0] col_q[$];

    int         mx[2], my[2];
    logic       mdx[2], mdy[2];
    logic [7:0] mcol[2];
    int         xmax[2] = '{608, 32};
    int         ymax[2] = '{448, 32};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            mx[w] = xmax[w] / 2;  my[w] = ymax[w] / 2;
            mdx[w] = 1'b1;        mdy[w] = 1'b1;
            mcol[w] = 8'hE0;
        end
    endtask

    task automatic model_step(input int w, input int spd, output upd_t e);
        logic hx, hy;
        hx = 1'b0; hy = 1'b0;
        if (spd > 0) begin
            if (mdx[w]) begin
                if (mx[w] + spd >= xmax[w]) begin mx[w] = xmax[w]; mdx[w] = 1'b0; hx = 1'b1; end
                else mx[w] = mx[w] + spd;
            end else begin
                if (mx[w] <= spd) begin mx[w] = 0; mdx[w] = 1'b1; hx = 1'b1; end
                else mx[w] = mx[w] - spd;
            end
            if (mdy[w]) begin
                if (my[w] + spd >= ymax[w]) begin my[w] = ymax[w]; mdy[w] = 1'b0; hy = 1'b1; end
                else my[w] = my[w] + spd;
            end else begin
                if (my[w] <= spd) begin my[w] = 0; mdy[w] = 1'b1; hy = 1'b1; end
                else my[w] = my[w] - spd;
            end
        end
        if (hx || hy) mcol[w] = mcol[w] + 8'h25;
        e.px = mx[w]; e.py = my[w]; e.hit = hx | hy; e.corner = hx & hy; e.col = mcol[w];
    endtask

    task automatic set_refresh(input int w, input logic v);
        if (w == 0) bi.REFRESH = v; else bs.REFRESH = v;
    endtask

    function automatic int dut_px(input int w);
        return (w == 0) ? int'(dut.pos_x) : int'(dsq.pos_x);
    endfunction

    function automatic int dut_py(input int w);
        return (w == 0) ? int'(dut.pos_y) : int'(dsq.pos_y);
    endfunction

    // One PIX_EN strobe; expected colour queued at drive time, popped once the output register loads.
    task automatic pix(input int w, input int h, input int v, input logic [7:0] exp, input string nm);
        if (w == 0) begin bi.ADDRH = 10'(h); bi.ADDRV = 9'(v); bi.PIX_EN = 1'b1; end
        else        begin bs.ADDRH = 10'(h); bs.ADDRV = 9'(v); bs.PIX_EN = 1'b1; end
        col_q.push_back(exp);
        @(posedge CLK); #1;
        bi.PIX_EN = 1'b0; bs.PIX_EN = 1'b0;
        chk(nm, (w == 0) ? bi.COLOUR : bs.COLOUR, col_q.pop_front());
    endtask

    task automatic run_update(input int w, input int spd, input string nm);
        upd_t e;
        int   hits, corners;
        model_step(w, spd, e);
        upd_q.push_back(e);
        if (w == 0) bi.SPEED = 3'(spd); else bs.SPEED = 3'(spd);
        set_refresh(w, 1'b1);
        @(posedge CLK); #1;
        set_refresh(w, 1'b0);
        hits = 0; corners = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) chk({nm, "_hit_commit"}, (w == 0) ? bi.HIT : bs.HIT, e.hit);
            hits    += (w == 0) ? int'(bi.HIT)    : int'(bs.HIT);
            corners += (w == 0) ? int'(bi.CORNER) : int'(bs.CORNER);
            @(posedge CLK); #1;
        end
        e = upd_q.pop_front();
        chk({nm, "_hits"},    hits,      e.hit    ? 1 : 0);
        chk({nm, "_corners"}, corners,   e.corner ? 1 : 0);
        chk({nm, "_px"},      dut_px(w), e.px);
        chk({nm, "_py"},      dut_py(w), e.py);
        pix(w, e.px, e.py, e.col, {nm, "_boxcol"});
    endtask

    pix_vec_t vecs[12];
    int       hits;
    upd_t     e;

    initial begin
        vecs[0]  = '{304, 224, 8'hE0};
        vecs[1]  = '{0,   100, 8'hFF};
        vecs[2]  = '{100, 100, 8'h00};
        vecs[3]  = '{335, 255, 8'hE0};
        vecs[4]  = '{336, 224, 8'h00};
        vecs[5]  = '{303, 224, 8'h00};
        vecs[6]  = '{639, 479, 8'hFF};
        vecs[7]  = '{304, 255, 8'hE0};
        vecs[8]  = '{304, 256, 8'h00};
        vecs[9]  = '{100, 0,   8'hFF};
        vecs[10] = '{100, 479, 8'hFF};
        vecs[11] = '{639, 300, 8'hFF};

        bi.PIX_EN = 0; bi.ADDRH = 0; bi.ADDRV = 0; bi.REFRESH = 0; bi.PAUSE = 0; bi.SPEED = 0;
        bs.PIX_EN = 0; bs.ADDRH = 0; bs.ADDRV = 0; bs.REFRESH = 0; bs.PAUSE = 0; bs.SPEED = 0;
        model_reset();
        RESETN = 1'b0;
        #12;
        chk("rst_pos_x",  dut.pos_x, 304);
        chk("rst_pos_y",  dut.pos_y, 224);
        chk("rst_colour", bi.COLOUR, 0);
        chk("rst_hit",    bi.HIT,    0);
        chk("rst_corner", bi.CORNER, 0);
        chk("rst_sq_pos", dsq.pos_x, 16);
        @(negedge CLK) RESETN = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 12; i++) pix(0, vecs[i].h, vecs[i].v, vecs[i].c, $sformatf("vec%0d", i));

        // COLOUR must hold while PIX_EN is low.
        bi.ADDRH = 10'd304; bi.ADDRV = 9'd224;
        @(posedge CLK); #1;
        chk("pix_en_hold", bi.COLOUR, 8'hFF);

        run_update(0, 3, "spd3");
        chk("spd3_x_const", dut.pos_x, 307);
        chk("spd3_y_const", dut.pos_y, 227);
        pix(0, 306, 227, 8'h00, "spd3_left_edge");

        for (int i = 0; i < 3;  i++) run_update(0, 1, "spd1");
        for (int i = 0; i < 59; i++) run_update(0, 5, "spd5");
        chk("pre_edge_x", dut.pos_x, 605);
        run_update(0, 5, "edge_x");
        chk("edge_x_pos",  dut.pos_x, 608);
        chk("edge_x_dir",  dut.dir_x, 0);
        pix(0, 608, 368, 8'h2A, "edge_x_col");
        pix(0, 639, 368, 8'h2A, "box_over_border");
        pix(0, 607, 368, 8'h00, "left_of_box");

        bi.PAUSE = 1'b1; hits = 0;
        repeat (3) begin
            bi.REFRESH = 1'b1; @(posedge CLK); #1; bi.REFRESH = 1'b0;
            repeat (4) begin hits += int'(bi.HIT); @(posedge CLK); #1; end
        end
        bi.PAUSE = 1'b0;
        chk("pause_hits", hits, 0);
        chk("pause_x", dut.pos_x, 608);
        chk("pause_y", dut.pos_y, 368);
        pix(0, 608, 368, 8'h2A, "pause_col");

        model_step(0, 2, e);
        bi.SPEED = 3'd2; bi.REFRESH = 1'b1;
        @(posedge CLK); #1; bi.REFRESH = 1'b0;
        @(posedge CLK); #1; bi.REFRESH = 1'b1;
        @(posedge CLK); #1; bi.REFRESH = 1'b0;
        hits = 0;
        repeat (8) begin hits += int'(bi.HIT); @(posedge CLK); #1; end
        chk("inject_hits", hits, 0);
        chk("inject_x", dut.pos_x, 606);
        chk("inject_y", dut.pos_y, 366);

        pix(0, 606, 366, 8'h2A, "pre_reset_col");
        bi.SPEED = 3'd3; bi.REFRESH = 1'b1;
        @(posedge CLK); #1; bi.REFRESH = 1'b0;
        RESETN = 1'b0; #1;
        chk("midrst_x",      dut.pos_x, 304);
        chk("midrst_y",      dut.pos_y, 224);
        chk("midrst_colour", bi.COLOUR, 0);
        chk("midrst_hit",    bi.HIT,    0);
        chk("midrst_state",  dut.state, IDLE);
        @(negedge CLK) RESETN = 1'b1;
        @(posedge CLK); #1;
        model_reset();
        run_update(0, 3, "post_rst");
        chk("post_rst_x", dut.pos_x, 307);
        chk("post_rst_y", dut.pos_y, 227);

        for (int i = 0; i < 4; i++) run_update(1, 4, "sq_a");
        chk("sq_a_x", dsq.pos_x, 32);
        chk("sq_a_y", dsq.pos_y, 32);
        pix(1, 32, 32, 8'h05, "sq_a_col");
        for (int i = 0; i < 6; i++) run_update(1, 5, "sq_b");
        chk("sq_b_x", dsq.pos_x, 2);
        run_update(1, 4, "sq_c");
        chk("sq_c_x", dsq.pos_x, 0);
        chk("sq_c_y", dsq.pos_y, 0);
        pix(1, 0, 0, 8'h2A, "sq_c_col");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
